// File: rtl/mem_arbiter.sv
// Three-way arbiter (reprogram, DMA, CPU) in front of the single memory port.
// One transaction at a time: IDLE -> BUSY -> DONE, fixed priority with a DMA burst cap.
module mem_arbiter #(
   parameter int unsigned DMA_BURST = 4
) (
   input  logic        clk,
   input  logic        rstn,
   input  logic        rpg_mode,
   input  logic [31:0] rq_addr  [3],
   input  logic [31:0] rq_wdata [3],
   input  logic [1:0]  rq_width [3],
   input  logic        rq_read  [3],
   input  logic        rq_write [3],
   output logic [31:0] rq_rdata [3],
   output logic        rq_ok    [3],
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic [1:0]  mem_width,
   output logic        mem_read,
   output logic        mem_write,
   input  logic [31:0] mem_rdata,
   input  logic        mem_ok
);

   typedef enum logic [1:0] {
      IDLE,
      BUSY,
      DONE
   } state_t;

   localparam logic [3:0] BURST_MAX = 4'(DMA_BURST);

   state_t     state;
   state_t     state_next;
   logic [2:0] active;
   logic       grant;
   logic [1:0] win;
   logic [1:0] owner;
   logic [3:0] burst_cnt;
   logic       burst_full;
   logic       finish;

   always_comb begin
      active[0] = rq_read[0] | rq_write[0];
      active[1] = (rq_read[1] | rq_write[1]) & ~rpg_mode;
      active[2] = (rq_read[2] | rq_write[2]) & ~rpg_mode;
   end

   assign burst_full = (burst_cnt == BURST_MAX);
   assign grant      = (state == IDLE) && (active != 3'b000);
   assign finish     = (state == BUSY) && mem_ok;

   // DMA yields to a waiting CPU once it has used up its burst allowance.
   always_comb begin
      win = 2'd0;
      if (active[0]) begin
         win = 2'd0;
      end else if (active[1] && !(active[2] && burst_full)) begin
         win = 2'd1;
      end else if (active[2]) begin
         win = 2'd2;
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (grant) state_next = BUSY;
         BUSY:    if (mem_ok) state_next = DONE;
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         mem_addr  <= '0;
         mem_wdata <= '0;
         mem_width <= '0;
         mem_read  <= 1'b0;
         mem_write <= 1'b0;
         owner     <= '0;
         burst_cnt <= '0;
      end else if (grant) begin
         mem_addr  <= rq_addr[win];
         mem_wdata <= rq_wdata[win];
         mem_width <= rq_width[win];
         mem_read  <= rq_read[win] & ~rq_write[win];
         mem_write <= rq_write[win];
         owner     <= win;
         if (win == 2'd1 && active[2]) begin
            if (!burst_full) burst_cnt <= burst_cnt + 4'd1;
         end else if (win == 2'd2 || !active[2]) begin
            burst_cnt <= '0;
         end
      end else if (finish) begin
         mem_read  <= 1'b0;
         mem_write <= 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         for (int unsigned i = 0; i < 3; i++) begin
            rq_rdata[i] <= '0;
            rq_ok[i]    <= 1'b0;
         end
      end else begin
         for (int unsigned i = 0; i < 3; i++) begin
            rq_ok[i] <= finish && (owner == 2'(i));
            if (finish && (owner == 2'(i))) rq_rdata[i] <= mem_rdata;
         end
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: stimulus pushes expected grants, a monitor checks
// each downstream request and each completion pulse against the queue head.
module tb_mem_arbiter;

   typedef struct {
      logic [1:0]  idx;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [1:0]  width;
      logic        wr;
      int unsigned lat;
   } exp_t;

   logic        clk;
   logic        rstn;
   logic        rpg_mode;
   logic [31:0] rq_addr  [3];
   logic [31:0] rq_wdata [3];
   logic [1:0]  rq_width [3];
   logic        rq_read  [3];
   logic        rq_write [3];
   logic [31:0] rq_rdata [3];
   logic        rq_ok    [3];
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [1:0]  mem_width;
   logic        mem_read;
   logic        mem_write;
   logic [31:0] mem_rdata;
   logic        mem_ok;

   exp_t        exp_q[$];
   int          tests;
   int          fails;
   int          rem[3];
   int unsigned mem_lat;

   mem_arbiter #(.DMA_BURST(4)) dut (
      .clk(clk), .rstn(rstn), .rpg_mode(rpg_mode),
      .rq_addr(rq_addr), .rq_wdata(rq_wdata), .rq_width(rq_width),
      .rq_read(rq_read), .rq_write(rq_write),
      .rq_rdata(rq_rdata), .rq_ok(rq_ok),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_width(mem_width),
      .mem_read(mem_read), .mem_write(mem_write),
      .mem_rdata(mem_rdata), .mem_ok(mem_ok)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Memory returns addr ^ DDADBEEF, so 0x0300_0000 reads back 0xDEADBEEF.
   function automatic logic [31:0] resp(input logic [31:0] a);
      return a ^ 32'hDDAD_BEEF;
   endfunction

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
      tests++;
      if (got !== want) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, got, want);
      end
   endtask

   task automatic push(input int i, input logic [31:0] a, input logic [31:0] d,
                       input logic [1:0] w, input logic wr, input int unsigned lat);
      exp_t e;
      e.idx = 2'(i); e.addr = a; e.wdata = d; e.width = w; e.wr = wr; e.lat = lat;
      exp_q.push_back(e);
   endtask

   task automatic issue(input int i, input logic [31:0] a, input logic [31:0] d,
                        input logic [1:0] w, input logic rd, input logic wr, input int n);
      rq_addr[i] = a; rq_wdata[i] = d; rq_width[i] = w;
      rem[i] = n; rq_read[i] = rd; rq_write[i] = wr;
   endtask

   task automatic wait_q(input string name, input int size, input int max);
      int n = 0;
      while (exp_q.size() > size && n < max) begin
         @(negedge clk);
         n++;
      end
      check(name, 32'(exp_q.size()), 32'(size));
   endtask

   task automatic wait_active(input string name, input int max);
      int n = 0;
      while (!(mem_read || mem_write) && n < max) begin
         @(negedge clk);
         n++;
      end
      check(name, 32'(mem_read | mem_write), 32'd1);
   endtask

   // Downstream memory model.
   initial begin
      int unsigned busy_cnt;
      busy_cnt = 0;
      mem_ok = 1'b0;
      mem_rdata = '0;
      forever begin
         @(negedge clk);
         if (mem_read || mem_write) begin
            busy_cnt++;
            mem_ok = (busy_cnt >= mem_lat);
            mem_rdata = resp(mem_addr);
         end else begin
            busy_cnt = 0;
            mem_ok = 1'b0;
         end
      end
   end

   // Requesters release strobes after their last completion.
   initial begin
      forever begin
         @(negedge clk);
         for (int i = 0; i < 3; i++) begin
            if (rq_ok[i] && rem[i] > 0) begin
               rem[i]--;
               if (rem[i] == 0) begin
                  rq_read[i] = 1'b0;
                  rq_write[i] = 1'b0;
               end
            end
         end
      end
   end

   // Monitor.
   initial begin
      logic in_txn;
      int unsigned cyc;
      int nok;
      exp_t f;
      in_txn = 1'b0;
      cyc = 0;
      forever begin
         @(negedge clk);
         if (!rstn) begin
            in_txn = 1'b0;
         end else begin
            if ((mem_read || mem_write) && !in_txn) begin
               in_txn = 1'b1;
               cyc = 0;
               check("grant_expected", 32'(exp_q.size() != 0), 32'd1);
               if (exp_q.size() != 0) begin
                  f = exp_q[0];
                  check("mem_addr", mem_addr, f.addr);
                  check("mem_wdata", mem_wdata, f.wdata);
                  check("mem_width", 32'(mem_width), 32'(f.width));
                  check("mem_write", 32'(mem_write), 32'(f.wr));
                  check("mem_read", 32'(mem_read), 32'(!f.wr));
               end
            end
            if (mem_read || mem_write) cyc++;
            nok = int'(rq_ok[0]) + int'(rq_ok[1]) + int'(rq_ok[2]);
            if (nok != 0) begin
               check("ok_onehot", 32'(nok), 32'd1);
               check("strobe_in_done", 32'(mem_read | mem_write), 32'd0);
               check("ok_expected", 32'(exp_q.size() != 0), 32'd1);
               if (exp_q.size() != 0) begin
                  f = exp_q.pop_front();
                  check("ok_owner", 32'(rq_ok[f.idx]), 32'd1);
                  check("rq_rdata", rq_rdata[f.idx], resp(f.addr));
                  check("busy_cycles", cyc, f.lat);
               end
               in_txn = 1'b0;
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      tests = 0; fails = 0; mem_lat = 1;
      rstn = 1'b0; rpg_mode = 1'b0;
      for (int i = 0; i < 3; i++) begin
         rq_addr[i] = '0; rq_wdata[i] = '0; rq_width[i] = '0;
         rq_read[i] = 1'b0; rq_write[i] = 1'b0; rem[i] = 0;
      end
      repeat (2) @(negedge clk);
      check("rst_mem_addr", mem_addr, 32'h0);
      check("rst_mem_wdata", mem_wdata, 32'h0);
      check("rst_mem_rw", {30'h0, mem_read, mem_write}, 32'h0);
      for (int i = 0; i < 3; i++) begin
         check("rst_rq_ok", 32'(rq_ok[i]), 32'd0);
         check("rst_rq_rdata", rq_rdata[i], 32'h0);
      end
      rstn = 1'b1;
      @(negedge clk);

      // Single CPU read, two BUSY cycles.
      mem_lat = 2;
      push(2, 32'h0300_0000, 32'h0, 2'd2, 1'b0, 2);
      issue(2, 32'h0300_0000, 32'h0, 2'd2, 1'b1, 1'b0, 1);
      wait_q("t1_drain", 0, 50);
      check("t1_rdata", rq_rdata[2], 32'hDEAD_BEEF);
      check("t1_rpg_hold", rq_rdata[0], 32'h0);
      check("t1_dma_hold", rq_rdata[1], 32'h0);

      // Simultaneous writes from all three.
      mem_lat = 1;
      push(0, 32'h0800_0000, 32'h1111_1111, 2'd2, 1'b1, 1);
      push(1, 32'h0100_0004, 32'h2222_2222, 2'd1, 1'b1, 1);
      push(2, 32'h0300_0008, 32'h3333_3333, 2'd0, 1'b1, 1);
      issue(0, 32'h0800_0000, 32'h1111_1111, 2'd2, 1'b0, 1'b1, 1);
      issue(1, 32'h0100_0004, 32'h2222_2222, 2'd1, 1'b0, 1'b1, 1);
      issue(2, 32'h0300_0008, 32'h3333_3333, 2'd0, 1'b1, 1'b1, 1);
      wait_q("t2_drain", 0, 60);
      repeat (2) @(negedge clk);

      // Continuous DMA and CPU: dma x4, cpu, dma x4, cpu.
      for (int r = 0; r < 2; r++) begin
         for (int k = 0; k < 4; k++) push(1, 32'h0100_0100, 32'h0, 2'd2, 1'b0, 1);
         push(2, 32'h0300_0100, 32'h0, 2'd2, 1'b0, 1);
      end
      issue(1, 32'h0100_0100, 32'h0, 2'd2, 1'b1, 1'b0, 8);
      issue(2, 32'h0300_0100, 32'h0, 2'd2, 1'b1, 1'b0, 2);
      wait_q("t3_drain", 0, 200);
      repeat (2) @(negedge clk);

      // rpg_mode blocks dma/cpu; rpg write proceeds; then dma, cpu.
      rpg_mode = 1'b1;
      push(0, 32'h0800_0010, 32'hA5A5_0010, 2'd2, 1'b1, 1);
      push(1, 32'h0100_0200, 32'h0, 2'd2, 1'b0, 1);
      push(2, 32'h0300_0200, 32'h0, 2'd2, 1'b0, 1);
      issue(1, 32'h0100_0200, 32'h0, 2'd2, 1'b1, 1'b0, 1);
      issue(2, 32'h0300_0200, 32'h0, 2'd2, 1'b1, 1'b0, 1);
      repeat (6) @(negedge clk);
      check("t4_blocked", 32'(exp_q.size()), 32'd3);
      issue(0, 32'h0800_0010, 32'hA5A5_0010, 2'd2, 1'b0, 1'b1, 1);
      wait_q("t4_rpg_done", 2, 50);
      rpg_mode = 1'b0;
      wait_q("t4_drain", 0, 60);
      repeat (2) @(negedge clk);

      // rpg_mode rises during a CPU transaction.
      mem_lat = 3;
      push(2, 32'h0300_0300, 32'h0, 2'd2, 1'b0, 3);
      push(0, 32'h0800_0020, 32'h5A5A_0020, 2'd2, 1'b1, 3);
      push(1, 32'h0100_0300, 32'h0, 2'd2, 1'b0, 3);
      issue(2, 32'h0300_0300, 32'h0, 2'd2, 1'b1, 1'b0, 1);
      wait_active("t5_cpu_busy", 20);
      rpg_mode = 1'b1;
      issue(1, 32'h0100_0300, 32'h0, 2'd2, 1'b1, 1'b0, 1);
      wait_q("t5_cpu_done", 2, 50);
      repeat (3) @(negedge clk);
      check("t5_dma_blocked", 32'(exp_q.size()), 32'd2);
      issue(0, 32'h0800_0020, 32'h5A5A_0020, 2'd2, 1'b0, 1'b1, 1);
      wait_q("t5_rpg_done", 1, 50);
      rpg_mode = 1'b0;
      wait_q("t5_drain", 0, 60);
      repeat (2) @(negedge clk);

      // Reset during BUSY drops the transaction; CPU is regranted after release.
      mem_lat = 20;
      push(2, 32'h0300_0400, 32'h0, 2'd2, 1'b0, 20);
      issue(2, 32'h0300_0400, 32'h0, 2'd2, 1'b1, 1'b0, 1);
      wait_active("t6_busy", 20);
      @(negedge clk);
      #2 rstn = 1'b0;
      #1;
      check("t6_async_rw", {30'h0, mem_read, mem_write}, 32'h0);
      check("t6_no_ok", 32'(rq_ok[2]), 32'd0);
      exp_q.delete();
      mem_lat = 1;
      push(2, 32'h0300_0400, 32'h0, 2'd2, 1'b0, 1);
      @(negedge clk);
      @(negedge clk);
      rstn = 1'b1;
      wait_q("t6_regrant", 0, 50);
      repeat (3) @(negedge clk);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
